// File: rtl/regbank_port_sequencer.sv
// Serialises one decoded-instruction request (writeback, then up to two source reads)
// onto the single-ported register bank and returns the operands via valid/ready.
module regbank_port_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr_en,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_nrd,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_op_a,
    output logic [DATA_W-1:0] rsp_op_b,
    output logic [ADDR_W-1:0] bank_sel,
    output logic              bank_treg,
    output logic              bank_lreg,
    output logic [DATA_W-1:0] bank_din,
    input  logic [DATA_W-1:0] bank_dout
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadA,
        StReadB,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          nrd_q, nrd_d;
    logic [ADDR_W-1:0]   rs1_q, rs1_d;
    logic [ADDR_W-1:0]   rs2_q, rs2_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [1:0]          nrd_clamp;

    assign nrd_clamp = (req_nrd == 2'd3) ? 2'd2 : req_nrd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wr_en_q <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            nrd_q   <= 2'd0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            nrd_q   <= nrd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en_d = wr_en_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        nrd_d   = nrd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        case (state_q)
            StIdle: begin
                // req_ready is only low in IDLE during reset, which holds the flops anyway
                if (req_valid) begin
                    wr_en_d = req_wr_en;
                    rd_d    = req_rd;
                    wdata_d = req_wdata;
                    nrd_d   = nrd_clamp;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    op_a_d  = '0;
                    op_b_d  = '0;
                    if (req_wr_en) begin
                        state_d = StWrite;
                    end else if (nrd_clamp != 2'd0) begin
                        state_d = StReadA;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWrite: begin
                state_d = (nrd_q != 2'd0) ? StReadA : StResp;
            end
            StReadA: begin
                op_a_d  = bank_dout;
                state_d = (nrd_q == 2'd2) ? StReadB : StResp;
            end
            StReadB: begin
                op_b_d  = bank_dout;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bank port is decoded from registered state only, never from req_* or rsp_ready.
    always_comb begin
        bank_sel  = '0;
        bank_treg = 1'b0;
        bank_lreg = 1'b0;
        bank_din  = '0;
        case (state_q)
            StWrite: begin
                bank_lreg = 1'b1;
                bank_sel  = rd_q;
                bank_din  = wdata_q;
            end
            StReadA: begin
                bank_treg = 1'b1;
                bank_sel  = rs1_q;
            end
            StReadB: begin
                bank_treg = 1'b1;
                bank_sel  = rs2_q;
            end
            default: begin
                bank_sel = '0;
            end
        endcase
    end

    assign req_ready = (state_q == StIdle) && !rst;
    assign rsp_valid = (state_q == StResp);
    assign rsp_op_a  = op_a_q;
    assign rsp_op_b  = op_b_q;

endmodule

// File: tb/tb_regbank_port_sequencer.sv
// Drives directed and random requests through the sequencer against a behavioural
// 8x16 bank and a transaction-level reference model.
module tb_regbank_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr_en;
    logic [2:0]  req_rd;
    logic [15:0] req_wdata;
    logic [1:0]  req_nrd;
    logic [2:0]  req_rs1;
    logic [2:0]  req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_op_a;
    logic [15:0] rsp_op_b;
    logic [2:0]  bank_sel;
    logic        bank_treg;
    logic        bank_lreg;
    logic [15:0] bank_din;
    logic [15:0] bank_dout;

    logic [15:0] bank_mem [8];
    logic [15:0] ref_mem [8];

    int checks = 0;
    int errors = 0;

    regbank_port_sequencer #(
        .DATA_W(16),
        .ADDR_W(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr_en (req_wr_en),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
        .req_nrd   (req_nrd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op_a  (rsp_op_a),
        .rsp_op_b  (rsp_op_b),
        .bank_sel  (bank_sel),
        .bank_treg (bank_treg),
        .bank_lreg (bank_lreg),
        .bank_din  (bank_din),
        .bank_dout (bank_dout)
    );

    always #5 clk = ~clk;

    // Behavioural bank: combinational read, write on rising edge.
    assign bank_dout = bank_treg ? bank_mem[bank_sel] : 16'hDEAD;
    always @(posedge clk) begin
        if (bank_lreg) bank_mem[bank_sel] <= bank_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bank(input string tag);
        chk({tag, ".lreg"}, {31'd0, bank_lreg}, 32'd0);
        chk({tag, ".treg"}, {31'd0, bank_treg}, 32'd0);
        chk({tag, ".sel"}, {29'd0, bank_sel}, 32'd0);
        chk({tag, ".din"}, {16'd0, bank_din}, 32'd0);
    endtask

    // One full transaction; starts with DUT in IDLE, ends just after the retiring edge.
    task automatic run_txn(input logic wr, input logic [2:0] rd, input logic [15:0] wdata,
                           input logic [1:0] nrd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input int bp);
        int          n;
        int          nslots;
        logic        s_lreg [3];
        logic [2:0]  s_sel  [3];
        logic [15:0] s_din  [3];
        logic [15:0] exp_a;
        logic [15:0] exp_b;

        n      = (nrd == 2'd3) ? 2 : int'(nrd);
        nslots = 0;
        if (wr) begin
            s_lreg[nslots] = 1'b1; s_sel[nslots] = rd; s_din[nslots] = wdata; nslots++;
            ref_mem[rd] = wdata;
        end
        if (n >= 1) begin
            s_lreg[nslots] = 1'b0; s_sel[nslots] = rs1; s_din[nslots] = 16'd0; nslots++;
        end
        if (n == 2) begin
            s_lreg[nslots] = 1'b0; s_sel[nslots] = rs2; s_din[nslots] = 16'd0; nslots++;
        end
        exp_a = (n >= 1) ? ref_mem[rs1] : 16'd0;
        exp_b = (n == 2) ? ref_mem[rs2] : 16'd0;

        @(negedge clk);
        chk("idle.req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1'b1;
        req_wr_en = wr;
        req_rd    = rd;
        req_wdata = wdata;
        req_nrd   = nrd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        @(posedge clk);
        #1;
        // Scramble request inputs; they must be ignored until IDLE.
        req_wr_en = 1'($urandom);
        req_rd    = 3'($urandom);
        req_wdata = 16'($urandom);
        req_nrd   = 2'($urandom);
        req_rs1   = 3'($urandom);
        req_rs2   = 3'($urandom);

        for (int i = 0; i < nslots; i++) begin
            @(negedge clk);
            chk("slot.lreg", {31'd0, bank_lreg}, {31'd0, s_lreg[i]});
            chk("slot.treg", {31'd0, bank_treg}, {31'd0, ~s_lreg[i]});
            chk("slot.sel", {29'd0, bank_sel}, {29'd0, s_sel[i]});
            chk("slot.din", {16'd0, bank_din}, {16'd0, s_din[i]});
            chk("slot.rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("slot.req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
        end

        for (int i = 0; i <= bp; i++) begin
            @(negedge clk);
            chk("resp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("resp.op_a", {16'd0, rsp_op_a}, {16'd0, exp_a});
            chk("resp.op_b", {16'd0, rsp_op_b}, {16'd0, exp_b});
            chk("resp.req_ready", {31'd0, req_ready}, 32'd0);
            chk_idle_bank("resp");
            if (i == bp) rsp_ready = 1'b1;
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            bank_mem[i] = 16'd0;
            ref_mem[i]  = 16'd0;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr_en = 1'b0;
        req_rd    = 3'd0;
        req_wdata = 16'd0;
        req_nrd   = 2'd0;
        req_rs1   = 3'd0;
        req_rs2   = 3'd0;
        rsp_ready = 1'b0;

        #3;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.op_a", {16'd0, rsp_op_a}, 32'd0);
        chk("rst.op_b", {16'd0, rsp_op_b}, 32'd0);
        chk_idle_bank("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Plain writeback, no reads.
        run_txn(1'b1, 3'd5, 16'hA5A5, 2'd0, 3'd0, 3'd0, 0);
        chk("bank.r5", {16'd0, bank_mem[5]}, 32'h0000A5A5);

        // Preload then dual read.
        run_txn(1'b1, 3'd2, 16'h1234, 2'd0, 3'd0, 3'd0, 0);
        run_txn(1'b1, 3'd7, 16'hBEEF, 2'd0, 3'd0, 3'd0, 0);
        run_txn(1'b0, 3'd0, 16'h0000, 2'd2, 3'd2, 3'd7, 0);

        // Write-before-read hazard.
        run_txn(1'b1, 3'd3, 16'h1111, 2'd0, 3'd0, 3'd0, 0);
        run_txn(1'b1, 3'd3, 16'h00FF, 2'd2, 3'd3, 3'd3, 0);

        // Backpressure for 5 cycles.
        run_txn(1'b0, 3'd0, 16'h0000, 2'd2, 3'd2, 3'd5, 5);

        // nrd=3 clamps to 2; nrd=1 skips READ_B; nrd=0 no reads.
        run_txn(1'b0, 3'd0, 16'h0000, 2'd3, 3'd1, 3'd4, 0);
        run_txn(1'b0, 3'd0, 16'h0000, 2'd1, 3'd7, 3'd2, 1);
        run_txn(1'b0, 3'd0, 16'h0000, 2'd0, 3'd7, 3'd2, 0);

        // Abort with reset in READ_A after a committed write.
        @(negedge clk);
        chk("abort.req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr_en = 1'b1;
        req_rd    = 3'd6;
        req_wdata = 16'h5555;
        req_nrd   = 2'd2;
        req_rs1   = 3'd6;
        req_rs2   = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort.write_lreg", {31'd0, bank_lreg}, 32'd1);
        @(posedge clk);
        ref_mem[6] = 16'h5555;
        @(negedge clk);
        chk("abort.reada_treg", {31'd0, bank_treg}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_bank("abort");
        chk("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort.req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort.op_a", {16'd0, rsp_op_a}, 32'd0);
        @(negedge clk);
        chk("abort.rsp_valid_hold", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        chk("bank.r6", {16'd0, bank_mem[6]}, 32'h00005555);
        run_txn(1'b0, 3'd0, 16'h0000, 2'd1, 3'd6, 3'd0, 0);

        // Randomised transactions against the reference model.
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 3'($urandom), 16'($urandom), 2'($urandom),
                    3'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("final.bank", {16'd0, bank_mem[i]}, {16'd0, ref_mem[i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
